// File: rtl/hash_checker_if.sv
// Message-stream and result bundle for the hash_checker receive path.
// The master side drives the message words; the slave side is the checker.
interface hash_checker_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [W-1:0] exp_digest;
  logic         done;
  logic         match;
  logic [W-1:0] digest;
  logic         overflow;

  modport master (
    output in_valid, in_data, in_last, exp_digest,
    input  in_ready, done, match, digest, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, exp_digest,
    output in_ready, done, match, digest, overflow
  );
endinterface

// File: rtl/hash_checker.sv
// hash_checker: absorbs a message one word at a time with the rotate-xor-add
// digest, folds in the word count, and compares against the expected digest
// captured with the last word. Reports done/match/digest/overflow.
module hash_checker #(
  parameter int unsigned  W     = 8,
  parameter int unsigned  LEN_W = 8,
  parameter logic [W-1:0] IV    = 8'hA5,
  parameter int unsigned  ROT   = 3,
  parameter logic [W-1:0] K     = 8'h5A
) (
  input  logic           clk,
  input  logic           clr,
  hash_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_FINAL,
    ST_DONE
  } state_e;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_e           state_q,    state_d;
  logic [W-1:0]     h_q,        h_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic             ovf_q,      ovf_d;
  logic [W-1:0]     exp_q,      exp_d;
  logic             done_q,     done_d;
  logic             match_q,    match_d;
  logic [W-1:0]     digest_q,   digest_d;
  logic             overflow_q, overflow_d;

  logic             ready;
  logic             accept;
  logic [W-1:0]     len_ext;
  logic [W-1:0]     fin;

  // One absorb round: xor the word in, rotate left, add the round constant.
  function automatic logic [W-1:0] absorb(input logic [W-1:0] h, input logic [W-1:0] d);
    logic [W-1:0] x;
    x = h ^ d;
    return ((x << ROT) | (x >> (W - ROT))) + K;
  endfunction

  // Word count folded into the digest: truncated or zero-extended to W bits.
  if (LEN_W >= W) begin : g_len_trunc
    assign len_ext = len_q[W-1:0];
  end else begin : g_len_zext
    assign len_ext = {{(W-LEN_W){1'b0}}, len_q};
  end

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_ABSORB);
  assign accept = bus.in_valid && ready;
  assign fin    = h_q ^ len_ext;

  // Next-state and datapath update for the absorb/finalise sequence.
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    exp_d      = exp_q;
    done_d     = 1'b0;
    match_d    = match_q;
    digest_d   = digest_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE, ST_ABSORB: begin
        if (accept) begin
          h_d = absorb(h_q, bus.in_data);
          if (len_q == LEN_MAX) begin
            ovf_d = 1'b1;
          end else begin
            len_d = len_q + LEN_W'(1);
          end
          if (bus.in_last) begin
            exp_d   = bus.exp_digest;
            state_d = ST_FINAL;
          end else begin
            state_d = ST_ABSORB;
          end
        end
      end
      ST_FINAL: begin
        digest_d   = fin;
        match_d    = (fin == exp_q) && !ovf_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        h_d     = IV;
        len_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      h_q        <= IV;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      exp_q      <= '0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      digest_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      exp_q      <= exp_d;
      done_q     <= done_d;
      match_q    <= match_d;
      digest_q   <= digest_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.done     = done_q;
  assign bus.match    = match_q;
  assign bus.digest   = digest_q;
  assign bus.overflow = overflow_q;

endmodule
